// File: rtl/tetris_pkg.sv
// rtl/tetris_pkg.sv - shared grid geometry, VGA timing and colour constants
// Timing defaults are 640x480@60 with a 25 MHz pixel rate.
package tetris_pkg;

  localparam int GRID_W = 10;
  localparam int GRID_H = 20;
  localparam int CELLS  = GRID_W * GRID_H;
  localparam int COL_W  = $clog2(GRID_W);
  localparam int ROW_W  = $clog2(GRID_H);

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int CW = 10;
  typedef logic [CW-1:0] pos_t;
  typedef logic [11:0]   rgb12_t;

  localparam rgb12_t C_BLACK    = 12'h000;
  localparam rgb12_t C_BORDER   = 12'h888;
  localparam rgb12_t C_GRIDLINE = 12'h222;
  localparam rgb12_t C_PIECE    = 12'h0CF;
  localparam rgb12_t C_FLASH    = 12'hFFF;
  localparam rgb12_t C_OVER     = 12'hF00;

  function automatic logic [7:0] cell_idx(input logic [ROW_W-1:0] row, input logic [COL_W-1:0] col);
    return ({3'b000, row} * 8'd10) + {4'b0000, col};
  endfunction

endpackage

// File: rtl/vga_timing.sv
// rtl/vga_timing.sv - pixel enable divider, h/v counters and raw sync/active
// Raw signals are combinational from the counters; the renderer pipelines them.
module vga_timing
  import tetris_pkg::*;
#(
  parameter int CLK_DIV  = 2,
  parameter int H_ACT    = H_ACTIVE,
  parameter int H_FRONT  = H_FP,
  parameter int H_SYNC_W = H_SYNC,
  parameter int H_BACK   = H_BP,
  parameter int V_ACT    = V_ACTIVE,
  parameter int V_FRONT  = V_FP,
  parameter int V_SYNC_W = V_SYNC,
  parameter int V_BACK   = V_BP
) (
  input  logic clk,
  input  logic reset_n,
  output logic pe,
  output pos_t h,
  output pos_t v,
  output logic hs_raw,
  output logic vs_raw,
  output logic active_raw,
  output logic line_end,
  output logic snap_strobe
);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam pos_t H_LAST  = pos_t'(H_ACT + H_FRONT + H_SYNC_W + H_BACK - 1);
  localparam pos_t V_LAST  = pos_t'(V_ACT + V_FRONT + V_SYNC_W + V_BACK - 1);
  localparam pos_t H_ACT_P = pos_t'(H_ACT);
  localparam pos_t V_ACT_P = pos_t'(V_ACT);
  localparam pos_t HS_BEG  = pos_t'(H_ACT + H_FRONT);
  localparam pos_t HS_END  = pos_t'(H_ACT + H_FRONT + H_SYNC_W);
  localparam pos_t VS_BEG  = pos_t'(V_ACT + V_FRONT);
  localparam pos_t VS_END  = pos_t'(V_ACT + V_FRONT + V_SYNC_W);

  logic [DW-1:0] div;

  assign pe = (div == DIV_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      div <= '0;
    else if (pe)
      div <= '0;
    else
      div <= div + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h <= '0;
      v <= '0;
    end else if (pe) begin
      if (h == H_LAST) begin
        h <= '0;
        v <= (v == V_LAST) ? '0 : v + 1'b1;
      end else begin
        h <= h + 1'b1;
      end
    end
  end

  assign hs_raw      = !(h >= HS_BEG && h < HS_END);
  assign vs_raw      = !(v >= VS_BEG && v < VS_END);
  assign active_raw  = (h < H_ACT_P) && (v < V_ACT_P);
  assign line_end    = pe && (h == H_LAST);
  assign snap_strobe = pe && (h == '0) && (v == V_ACT_P);

endmodule

// File: rtl/tetris_vga_render.sv
// rtl/tetris_vga_render.sv - VGA renderer for the 10x20 tetris playfield
// Draws a per-frame grid snapshot with line-clear flash and game-over tint.
module tetris_vga_render
  import tetris_pkg::*;
#(
  parameter int CLK_DIV      = 2,
  parameter int X0           = 220,
  parameter int Y0           = 40,
  parameter int CELL         = 20,
  parameter int BORDER       = 4,
  parameter int FLASH_FRAMES = 8,
  parameter int H_ACT        = H_ACTIVE,
  parameter int H_FRONT      = H_FP,
  parameter int H_SYNC_W     = H_SYNC,
  parameter int H_BACK       = H_BP,
  parameter int V_ACT        = V_ACTIVE,
  parameter int V_FRONT      = V_FP,
  parameter int V_SYNC_W     = V_SYNC,
  parameter int V_BACK       = V_BP
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [CELLS-1:0] grid_state,
  input  logic             row_cleared,
  input  logic             game_over,
  output logic             vga_hs,
  output logic             vga_vs,
  output logic             vga_de,
  output logic [3:0]       vga_r,
  output logic [3:0]       vga_g,
  output logic [3:0]       vga_b,
  output logic             frame_start
);
  localparam int SW = (CELL > 1) ? $clog2(CELL) : 1;
  localparam int FW = $clog2(FLASH_FRAMES + 1);
  localparam logic [SW-1:0] SUB_LAST   = SW'(CELL - 1);
  localparam logic [FW-1:0] FLASH_LOAD = FW'(FLASH_FRAMES);
  localparam pos_t FX0     = pos_t'(X0);
  localparam pos_t FX1     = pos_t'(X0 + GRID_W * CELL);
  localparam pos_t FX_LAST = pos_t'(X0 + GRID_W * CELL - 1);
  localparam pos_t FY0     = pos_t'(Y0);
  localparam pos_t FY1     = pos_t'(Y0 + GRID_H * CELL);
  localparam pos_t FY_LAST = pos_t'(Y0 + GRID_H * CELL - 1);
  localparam pos_t BX0     = pos_t'(X0 - BORDER);
  localparam pos_t BX1     = pos_t'(X0 + GRID_W * CELL + BORDER);
  localparam pos_t BY0     = pos_t'(Y0 - BORDER);
  localparam pos_t BY1     = pos_t'(Y0 + GRID_H * CELL + BORDER);

  logic pe, hs_raw, vs_raw, active_raw, line_end, snap_strobe;
  pos_t h, v;

  vga_timing #(
    .CLK_DIV(CLK_DIV), .H_ACT(H_ACT), .H_FRONT(H_FRONT), .H_SYNC_W(H_SYNC_W), .H_BACK(H_BACK),
    .V_ACT(V_ACT), .V_FRONT(V_FRONT), .V_SYNC_W(V_SYNC_W), .V_BACK(V_BACK)
  ) u_timing (
    .clk(clk), .reset_n(reset_n), .pe(pe), .h(h), .v(v), .hs_raw(hs_raw), .vs_raw(vs_raw),
    .active_raw(active_raw), .line_end(line_end), .snap_strobe(snap_strobe)
  );

  assign frame_start = snap_strobe;

  logic [CELLS-1:0] snap;
  logic             go_snap, rc_d, rc_rise;
  logic [FW-1:0]    flash_cnt;

  assign rc_rise = row_cleared && !rc_d;

  // A fresh row_cleared edge beats the per-frame decrement when both land together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      snap      <= '0;
      go_snap   <= 1'b0;
      rc_d      <= 1'b0;
      flash_cnt <= '0;
    end else begin
      rc_d <= row_cleared;
      if (snap_strobe) begin
        snap    <= grid_state;
        go_snap <= game_over;
      end
      if (rc_rise)
        flash_cnt <= FLASH_LOAD;
      else if (snap_strobe && flash_cnt != '0)
        flash_cnt <= flash_cnt - 1'b1;
    end
  end

  // Cell coordinates run alongside h/v so no divider is needed.
  logic [SW-1:0]    sub_x, sub_y;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sub_x <= '0;
      col   <= '0;
    end else if (pe) begin
      if (h >= FX0 && h < FX_LAST) begin
        if (sub_x == SUB_LAST) begin
          sub_x <= '0;
          col   <= col + 1'b1;
        end else begin
          sub_x <= sub_x + 1'b1;
        end
      end else begin
        sub_x <= '0;
        col   <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sub_y <= '0;
      row   <= '0;
    end else if (line_end) begin
      if (v >= FY0 && v < FY_LAST) begin
        if (sub_y == SUB_LAST) begin
          sub_y <= '0;
          row   <= row + 1'b1;
        end else begin
          sub_y <= sub_y + 1'b1;
        end
      end else begin
        sub_y <= '0;
        row   <= '0;
      end
    end
  end

  logic in_field, in_box;
  assign in_field = (h >= FX0 && h < FX1 && v >= FY0 && v < FY1);
  assign in_box   = (h >= BX0 && h < BX1 && v >= BY0 && v < BY1);

  logic             s1_active, s1_field, s1_border, s1_grid, s1_hs, s1_vs;
  logic [COL_W-1:0] s1_col;
  logic [ROW_W-1:0] s1_row;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_active <= 1'b0;
      s1_field  <= 1'b0;
      s1_border <= 1'b0;
      s1_grid   <= 1'b0;
      s1_hs     <= 1'b1;
      s1_vs     <= 1'b1;
      s1_col    <= '0;
      s1_row    <= '0;
    end else if (pe) begin
      s1_active <= active_raw;
      s1_field  <= in_field;
      s1_border <= in_box && !in_field;
      s1_grid   <= (sub_x == '0) || (sub_y == '0);
      s1_hs     <= hs_raw;
      s1_vs     <= vs_raw;
      s1_col    <= col;
      s1_row    <= row;
    end
  end

  rgb12_t pix;
  always_comb begin
    pix = C_BLACK;
    if (!s1_active)
      pix = C_BLACK;
    else if (s1_border)
      pix = C_BORDER;
    else if (s1_field) begin
      if (s1_grid)
        pix = C_GRIDLINE;
      else if (snap[cell_idx(s1_row, s1_col)])
        pix = go_snap ? C_OVER : ((flash_cnt != '0) ? C_FLASH : C_PIECE);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vga_hs <= 1'b1;
      vga_vs <= 1'b1;
      vga_de <= 1'b0;
      {vga_r, vga_g, vga_b} <= C_BLACK;
    end else if (pe) begin
      vga_hs <= s1_hs;
      vga_vs <= s1_vs;
      vga_de <= s1_active;
      {vga_r, vga_g, vga_b} <= pix;
    end
  end

endmodule

// File: tb/tb_tetris_vga_render.sv
// tb/tb_tetris_vga_render.sv - self-checking bench for tetris_vga_render
// Runs a shrunken raster so many frames fit in a short simulation.
module tb_tetris_vga_render;
  localparam int X0 = 4, Y0 = 4, CELL = 2, BORDER = 2, FLASH = 4;
  localparam int HA = 28, HF = 2, HSW = 3, HB = 3, HT = HA + HF + HSW + HB;
  localparam int VA = 48, VF = 2, VSW = 2, VB = 2, VT = VA + VF + VSW + VB;
  localparam int FRAME = HT * VT;

  logic         clk = 1'b0;
  logic         reset_n = 1'b1;
  logic [199:0] grid_state = '0;
  logic         row_cleared = 1'b0;
  logic         game_over = 1'b0;
  logic         vga_hs, vga_vs, vga_de, frame_start;
  logic [3:0]   vga_r, vga_g, vga_b;

  int pcount;
  int total = 0;
  int passed = 0;
  logic mon_done = 1'b0;

  tetris_vga_render #(
    .CLK_DIV(2), .X0(X0), .Y0(Y0), .CELL(CELL), .BORDER(BORDER), .FLASH_FRAMES(FLASH),
    .H_ACT(HA), .H_FRONT(HF), .H_SYNC_W(HSW), .H_BACK(HB),
    .V_ACT(VA), .V_FRONT(VF), .V_SYNC_W(VSW), .V_BACK(VB)
  ) dut (
    .clk(clk), .reset_n(reset_n), .grid_state(grid_state), .row_cleared(row_cleared),
    .game_over(game_over), .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_de(vga_de),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge reset_n)
    if (!reset_n) pcount <= 0;
    else          pcount <= pcount + 1;

  typedef struct {
    int          f;
    int          x;
    int          y;
    logic [11:0] exp;
    bit          set199;
    string       name;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", name, got, exp);
    else             passed++;
  endtask

  // Clock count after reset release at which pixel (f,x,y) sits on the pins.
  function automatic int pc_of(input int f, input int x, input int y);
    return 2 * (f * FRAME + y * HT + x + 2);
  endfunction

  task automatic wait_pc(input int target);
    while (pcount < target) @(negedge clk);
  endtask

  function automatic logic [15:0] pins();
    return {vga_hs, vga_vs, vga_de, vga_r, vga_g, vga_b, frame_start};
  endfunction

  function automatic logic [11:0] rgb();
    return {vga_r, vga_g, vga_b};
  endfunction

  task automatic pulse_rc();
    row_cleared = 1'b1;
    @(negedge clk);
    row_cleared = 1'b0;
  endtask

  initial begin : timing_mon
    int x, y, hs_err, vs_err, de_err, hs_low, vs_low, de_cnt;
    logic eh, ev, ed;
    hs_err = 0; vs_err = 0; de_err = 0; hs_low = 0; vs_low = 0; de_cnt = 0;
    @(posedge reset_n);
    for (int p = 0; p < 2 * FRAME; p++) begin
      x = p % HT;
      y = (p / HT) % VT;
      wait_pc(2 * p + 4);
      eh = !(x >= HA + HF && x < HA + HF + HSW);
      ev = !(y >= VA + VF && y < VA + VF + VSW);
      ed = (x < HA) && (y < VA);
      if (vga_hs !== eh) hs_err++;
      if (vga_vs !== ev) vs_err++;
      if (vga_de !== ed) de_err++;
      if (vga_hs === 1'b0) hs_low++;
      if (vga_vs === 1'b0) vs_low++;
      if (vga_de === 1'b1) de_cnt++;
    end
    chk("hs_pattern_errors", hs_err, 0);
    chk("vs_pattern_errors", vs_err, 0);
    chk("de_pattern_errors", de_err, 0);
    chk("hs_low_pixels", hs_low, 2 * VT * HSW);
    chk("vs_low_pixels", vs_low, 2 * VSW * HT);
    chk("de_high_pixels", de_cnt, 2 * HA * VA);
    mon_done = 1'b1;
  end

  initial begin : main
    int p;
    bit found;
    grid_state[0] = 1'b1;
    #2 reset_n = 1'b0;
    #1 chk("reset_state", pins(), 16'hC000);

    vecs.push_back('{0,  5,  5, 12'h000, 1'b0, "pre_snapshot"});
    vecs.push_back('{1,  5,  3, 12'h888, 1'b0, "border_top"});
    vecs.push_back('{1,  1,  5, 12'h000, 1'b0, "outside_left"});
    vecs.push_back('{1,  2,  5, 12'h888, 1'b0, "border_left"});
    vecs.push_back('{1,  3,  5, 12'h888, 1'b0, "border_inner_edge"});
    vecs.push_back('{1,  4,  5, 12'h222, 1'b0, "gridline_x0"});
    vecs.push_back('{1,  5,  5, 12'h0CF, 1'b0, "cell0_filled"});
    vecs.push_back('{1,  7,  5, 12'h000, 1'b0, "cell1_empty"});
    vecs.push_back('{1, 25,  5, 12'h888, 1'b0, "border_right"});
    vecs.push_back('{1, 27,  5, 12'h000, 1'b0, "outside_right"});
    vecs.push_back('{1,  5, 21, 12'h000, 1'b1, "row8_empty"});
    vecs.push_back('{1, 23, 43, 12'h000, 1'b0, "bit199_same_frame"});
    vecs.push_back('{2,  5,  5, 12'h0CF, 1'b0, "cell0_frame2"});
    vecs.push_back('{2, 23, 43, 12'h0CF, 1'b0, "bit199_next_frame"});

    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      wait_pc(pc_of(vecs[i].f, vecs[i].x, vecs[i].y));
      chk(vecs[i].name, rgb(), vecs[i].exp);
      if (vecs[i].set199) grid_state[199] = 1'b1;
    end

    // Snapshot of frame 2 happens in the pe clock of pixel (0, VA).
    p = 2 * FRAME + VA * HT;
    wait_pc(2 * p);     chk("frame_start_before", frame_start, 0);
    wait_pc(2 * p + 1); chk("frame_start_pulse", frame_start, 1);
    wait_pc(2 * p + 2); chk("frame_start_after", frame_start, 0);

    wait_pc(pc_of(2, 0, 50));
    pulse_rc();
    wait_pc(pc_of(3, 5, 5));   chk("flash_f3_cell0", rgb(), 12'hFFF);
    wait_pc(pc_of(3, 23, 43)); chk("flash_f3_bit199", rgb(), 12'hFFF);
    wait_pc(pc_of(4, 5, 5));   chk("flash_f4_cell0", rgb(), 12'hFFF);

    // Reload lands on the same clock as the frame-4 snapshot.
    p = 4 * FRAME + VA * HT;
    wait_pc(2 * p + 1);
    pulse_rc();
    for (int f = 5; f <= 8; f++) begin
      wait_pc(pc_of(f, 5, 5));
      chk($sformatf("reflash_f%0d", f), rgb(), 12'hFFF);
    end
    wait_pc(pc_of(9, 5, 5));   chk("flash_done_cell0", rgb(), 12'h0CF);
    wait_pc(pc_of(9, 23, 43)); chk("flash_done_bit199", rgb(), 12'h0CF);

    wait_pc(pc_of(9, 0, 46));
    game_over = 1'b1;
    pulse_rc();
    wait_pc(pc_of(10, 4, 5));   chk("over_gridline", rgb(), 12'h222);
    wait_pc(pc_of(10, 5, 5));   chk("over_cell0", rgb(), 12'hF00);
    wait_pc(pc_of(10, 23, 43)); chk("over_bit199", rgb(), 12'hF00);

    wait_pc(pc_of(11, 3, 20)); chk("pre_reset_border", rgb(), 12'h888);
    reset_n = 1'b0;
    #1 chk("reset_async", pins(), 16'hC000);
    repeat (3) @(negedge clk);
    chk("reset_hold", pins(), 16'hC000);
    reset_n = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (vga_hs === 1'b0) found = 1'b1;
    end
    chk("first_hs_low_clk", found ? pcount : -1, 2 * (HA + HF + 2));
    wait_pc(pc_of(0, 2, 5)); chk("border_after_reset", rgb(), 12'h888);
    wait_pc(pc_of(0, 5, 5)); chk("snapshot_cleared", rgb(), 12'h000);

    for (int i = 0; i < 20000 && !mon_done; i++) @(negedge clk);
    chk("timing_monitor_done", mon_done, 1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
